input_port_buffer: RTL and testbench

Per-port ingress buffer of the mesh router: receives flits from the neighbouring router's registered output stage, stores them in a DEPTH-entry FIFO, and presents the head flit with its one-hot XY-routing label to the unicast arbiter. It is the receiving end of the `data_out`/`valid_out`/`full` link and the producer of the `label`/`data_in` inputs, consuming the arbiter's `ready`. One instance sits on each of the L, N, E, S and W ports.

---
 rtl/input_port_buffer.sv | 132 +++++++++++++
 tb/tb_input_port_buffer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/input_port_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : input_port_buffer
//  Purpose  : Per-port ingress FIFO of the mesh router. Stores incoming flits
//             in a DEPTH-entry buffer and presents the head flit (first-word
//             fall-through) with its one-hot XY-routing label to the unicast
//             arbiter.
//  Ports    : ua_clk    - clock, rising edge
//             rst_n     - asynchronous reset, active-high (asserted when 1)
//             valid_in  - upstream flit valid
//             data_in   - upstream flit
//             full      - backpressure to upstream (count == DEPTH)
//             ready     - arbiter grant-and-accept, pops the head flit
//             data_out  - head flit, 0 when empty
//             label     - one-hot route {W,N,E,S,L}, 0 when empty
//             count     - occupancy 0..DEPTH
//  Revision : 1.0 - initial release
// ============================================================================
module input_port_buffer #(
    parameter int DEPTH     = 4,
    parameter int WIDTH     = 2,
    parameter int DATASIZE  = 30,
    parameter int ID_W      = 4,
    parameter int MESH_X    = 4,
    parameter int router_ID = 6
) (
    input  logic                ua_clk,
    input  logic                rst_n,
    input  logic                valid_in,
    input  logic [DATASIZE-1:0] data_in,
    output logic                full,
    input  logic                ready,
    output logic [DATASIZE-1:0] data_out,
    output logic [4:0]          label,
    output logic [WIDTH:0]      count
);

    // Router coordinates and the mesh width, sized to the destination field
    localparam logic [ID_W-1:0]  c_MESH_X = ID_W'(MESH_X);
    localparam logic [ID_W-1:0]  c_CX     = ID_W'(router_ID % MESH_X);
    localparam logic [ID_W-1:0]  c_CY     = ID_W'(router_ID / MESH_X);
    localparam logic [WIDTH:0]   c_DEPTH  = (WIDTH+1)'(DEPTH);

    // One-hot label encodings, bit order {W,N,E,S,L}
    localparam logic [4:0] c_LBL_W = 5'b10000;
    localparam logic [4:0] c_LBL_N = 5'b01000;
    localparam logic [4:0] c_LBL_E = 5'b00100;
    localparam logic [4:0] c_LBL_S = 5'b00010;
    localparam logic [4:0] c_LBL_L = 5'b00001;

    logic [DATASIZE-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0]    r_wp;
    logic [WIDTH-1:0]    r_rp;
    logic [WIDTH:0]      r_count;

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic [DATASIZE-1:0] w_head;
    logic [ID_W-1:0]     w_dest;
    logic [ID_W-1:0]     w_dx;
    logic [ID_W-1:0]     w_dy;
    logic [4:0]          w_label;

    // full is derived from the current count only, so a pop while full does
    // not admit a new flit until the following cycle.
    assign w_full  = (r_count == c_DEPTH);
    assign w_empty = (r_count == '0);
    assign w_push  = valid_in & ~w_full;
    assign w_pop   = ready & ~w_empty;

    // Pointers and occupancy; async reset discards all buffered flits
    always_ff @(posedge ua_clk or posedge rst_n) begin
        if (rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array carries no reset; stale entries are never presented
    // because the head is masked whenever the buffer is empty.
    always_ff @(posedge ua_clk) begin
        if (w_push) begin
            r_mem[r_wp] <= data_in;
        end
    end

    // First-word fall-through head
    assign w_head = w_empty ? '0 : r_mem[r_rp];
    assign w_dest = w_head[DATASIZE-1 -: ID_W];
    assign w_dx   = w_dest % c_MESH_X;
    assign w_dy   = w_dest / c_MESH_X;

    // XY routing: resolve X first, then Y (Y grows southward)
    always_comb begin
        w_label = '0;
        if (!w_empty) begin
            if (w_dx > c_CX) begin
                w_label = c_LBL_E;
            end else if (w_dx < c_CX) begin
                w_label = c_LBL_W;
            end else if (w_dy < c_CY) begin
                w_label = c_LBL_N;
            end else if (w_dy > c_CY) begin
                w_label = c_LBL_S;
            end else begin
                w_label = c_LBL_L;
            end
        end
    end

    assign full     = w_full;
    assign data_out = w_head;
    assign label    = w_label;
    assign count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_input_port_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_input_port_buffer
//  Purpose  : Self-checking bench for input_port_buffer (router 6 at (2,1) in
//             a 4-column mesh). Stimulus pushes expected flit/label pairs into
//             a queue; a monitor pops and compares whenever a flit leaves.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_input_port_buffer;

    localparam int DEPTH    = 4;
    localparam int WIDTH    = 2;
    localparam int DATASIZE = 30;

    localparam logic [4:0] c_W = 5'b10000;
    localparam logic [4:0] c_N = 5'b01000;
    localparam logic [4:0] c_E = 5'b00100;
    localparam logic [4:0] c_S = 5'b00010;
    localparam logic [4:0] c_L = 5'b00001;

    logic                ua_clk = 1'b0;
    logic                rst_n;
    logic                valid_in;
    logic [DATASIZE-1:0] data_in;
    logic                full;
    logic                ready;
    logic [DATASIZE-1:0] data_out;
    logic [4:0]          label;
    logic [WIDTH:0]      count;

    logic [4:0]          exp_lbl;   // hand-computed label of the flit on data_in

    typedef struct packed {
        logic [DATASIZE-1:0] d;
        logic [4:0]          l;
    } flit_t;

    flit_t q[$];
    int    m_cnt = 0;
    int    n_checks = 0;
    int    n_pass = 0;

    input_port_buffer #(
        .DEPTH(DEPTH), .WIDTH(WIDTH), .DATASIZE(DATASIZE),
        .ID_W(4), .MESH_X(4), .router_ID(6)
    ) dut (
        .ua_clk   (ua_clk),
        .rst_n    (rst_n),
        .valid_in (valid_in),
        .data_in  (data_in),
        .full     (full),
        .ready    (ready),
        .data_out (data_out),
        .label    (label),
        .count    (count)
    );

    always #5 ua_clk = ~ua_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [DATASIZE-1:0] mk(input int dest, input int payload);
        logic [3:0]  d4;
        logic [25:0] p;
        d4 = 4'(dest);
        p  = 26'(payload);
        return {d4, p};
    endfunction

    // Monitor / model: sample mid-cycle, inputs are stable here
    always @(negedge ua_clk) begin
        if (rst_n) begin
            q.delete();
            m_cnt = 0;
        end else begin
            chk("count", 32'(count), 32'(m_cnt));
            chk("full", 32'(full), 32'(m_cnt == DEPTH));
            if (m_cnt == 0) begin
                chk("empty_label", 32'(label), 32'd0);
                chk("empty_data", 32'(data_out), 32'd0);
            end
            if (ready && m_cnt != 0) begin
                chk("pop_data", 32'(data_out), 32'(q[0].d));
                chk("pop_label", 32'(label), 32'(q[0].l));
                void'(q.pop_front());
                m_cnt--;
            end
            if (valid_in && (m_cnt + (ready && m_cnt != 0 ? 1 : 0)) != DEPTH) begin
                q.push_back('{d: data_in, l: exp_lbl});
                m_cnt++;
            end
        end
    end

    // One clock cycle with the given inputs
    task automatic cyc(input logic v, input logic [DATASIZE-1:0] d, input logic [4:0] l,
                       input logic r);
        valid_in = v;
        data_in  = d;
        exp_lbl  = l;
        ready    = r;
        @(posedge ua_clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_label", 32'(label), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b1;
        valid_in = 1'b0;
        data_in  = '0;
        exp_lbl  = '0;
        ready    = 1'b0;
        #4;
        check_reset_outputs();
        @(posedge ua_clk);
        #1;
        rst_n = 1'b0;
        cyc(0, '0, '0, 0);

        // Routing: one label per destination, each popped in turn
        cyc(1, mk(7, 1),  c_E, 0);  cyc(0, '0, '0, 1);
        cyc(1, mk(4, 2),  c_W, 0);  cyc(0, '0, '0, 1);
        cyc(1, mk(2, 3),  c_N, 0);  cyc(0, '0, '0, 1);
        cyc(1, mk(14, 4), c_S, 0);  cyc(0, '0, '0, 1);
        cyc(1, mk(6, 5),  c_L, 0);  cyc(0, '0, '0, 1);

        // Fill: five pushes with ready low, fifth is refused
        cyc(1, mk(0, 16'hA), c_W, 0);
        cyc(1, mk(11, 16'hB), c_E, 0);
        cyc(1, mk(10, 16'hC), c_S, 0);
        cyc(1, mk(1, 16'hD), c_W, 0);
        cyc(1, mk(3, 16'hE), c_E, 0);
        // Pop while full: E still blocked, then accepted next cycle
        cyc(1, mk(3, 16'hE), c_E, 1);
        cyc(1, mk(3, 16'hE), c_E, 1);
        for (int i = 0; i < 4; i++) cyc(0, '0, '0, 1);

        // Simultaneous push/pop at count 2
        cyc(1, mk(5, 100), c_W, 0);
        cyc(1, mk(15, 101), c_E, 0);
        cyc(1, mk(2, 102), c_N, 1);
        cyc(1, mk(6, 103), c_L, 1);
        cyc(1, mk(14, 104), c_S, 1);
        cyc(1, mk(13, 105), c_W, 1);
        cyc(1, mk(7, 106), c_E, 1);
        cyc(1, mk(10, 107), c_S, 1);
        cyc(0, '0, '0, 1);
        cyc(0, '0, '0, 1);

        // Wrap-around: ten pushes interleaved with pops, varying fill level
        cyc(1, mk(0, 200), c_W, 0);
        cyc(1, mk(11, 201), c_E, 0);
        cyc(1, mk(2, 202), c_N, 1);
        cyc(0, '0, '0, 1);
        cyc(1, mk(6, 203), c_L, 0);
        cyc(1, mk(14, 204), c_S, 0);
        cyc(1, mk(3, 205), c_E, 1);
        cyc(0, '0, '0, 1);
        cyc(1, mk(1, 206), c_W, 0);
        cyc(1, mk(10, 207), c_S, 1);
        cyc(1, mk(7, 208), c_E, 0);
        cyc(1, mk(4, 209), c_W, 1);
        for (int i = 0; i < 5; i++) cyc(0, '0, '0, 1);

        // Reset mid-stream with three flits buffered
        cyc(1, mk(7, 300), c_E, 0);
        cyc(1, mk(4, 301), c_W, 0);
        cyc(1, mk(2, 302), c_N, 0);
        valid_in = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
        check_reset_outputs();
        @(posedge ua_clk);
        #1;
        rst_n = 1'b0;
        cyc(1, mk(6, 310), c_L, 0);
        cyc(0, '0, '0, 1);

        // Ready while empty
        for (int i = 0; i < 3; i++) cyc(0, '0, '0, 1);
        cyc(0, '0, '0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
